// File: rtl/mux_sel_pipe_pkg.sv
// Shared constants and helpers for the registered N-input selector.
package mux_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Channel index width. Never below one bit, so a single channel still has an index.
    function automatic int selw_f(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_sel_pipe_if.sv
// Producer/consumer bundle for mux_sel_pipe: per-channel valid/ready in, one valid/ready out.
interface mux_sel_pipe_if #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 32
);

    localparam int SELW = mux_pkg::selw_f(NUM_IN);

    logic                    rr_en;
    logic [SELW-1:0]         sel;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_src;
    logic                    out_ready;

    modport master (
        output rr_en, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  rr_en, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux_sel_pipe_rr_pick.sv
// Round-robin picker: first requester at or after the pointer, wrapping around.
module rr_pick #(
    parameter int NUM_IN = 4,
    parameter int SELW   = 2
) (
    input  logic [NUM_IN-1:0] i_req,
    input  logic [SELW-1:0]   i_ptr,
    output logic              o_gnt,
    output logic [SELW-1:0]   o_idx
);

    logic [NUM_IN-1:0] w_rot;
    logic              w_found;
    int                w_off;

    function automatic int wrapAdd(input int a, input int b);
        int s;
        s = a + b;
        if (s >= NUM_IN) s = s - NUM_IN;
        return s;
    endfunction

    // Rotate so the pointer channel lands at position 0.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (wrapAdd(int'(i_ptr), k) == i) w_rot[k] = i_req[i];
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_off   = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
    end

    always_comb begin
        o_gnt = w_found;
        o_idx = SELW'(wrapAdd(int'(i_ptr), w_off));
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N:1 selector with static or round-robin arbitration and a one-deep output register.
module mux_sel_pipe
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 32
) (
    input logic          clk,
    input logic          rst_n,
    mux_sel_pipe_if.slave bus
);

    localparam int SELW = selw_f(NUM_IN);

    logic              r_outValid;
    logic [WIDTH-1:0]  r_outData;
    logic [SELW-1:0]   r_outSrc;
    logic [SELW-1:0]   r_ptr;

    logic              w_load;
    logic              w_stGnt;
    logic              w_rrGnt;
    logic [SELW-1:0]   w_rrIdx;
    logic              w_gnt;
    logic [SELW-1:0]   w_gntIdx;
    logic [SELW-1:0]   w_ptrNext;
    logic [WIDTH-1:0]  w_selData;
    logic [NUM_IN-1:0] w_ready;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .SELW   (SELW)
    ) u_rr_pick (
        .i_req (bus.in_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_rrGnt),
        .o_idx (w_rrIdx)
    );

    assign w_load = ~r_outValid | bus.out_ready;

    // A select value with no matching channel simply never grants.
    always_comb begin
        w_stGnt = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SELW'(i)) w_stGnt = bus.in_valid[i];
        end
    end

    always_comb begin
        if (bus.rr_en == MODE_RR) begin
            w_gnt    = w_rrGnt;
            w_gntIdx = w_rrIdx;
        end else begin
            w_gnt    = w_stGnt;
            w_gntIdx = bus.sel;
        end
    end

    always_comb begin
        w_selData = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gntIdx == SELW'(i)) w_selData = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_ready[i] = rst_n & w_load & w_gnt & (w_gntIdx == SELW'(i));
        end
    end

    assign w_ptrNext = (w_gntIdx == SELW'(NUM_IN - 1)) ? '0 : w_gntIdx + SELW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSrc   <= '0;
            r_ptr      <= '0;
        end else if (w_load) begin
            if (w_gnt) begin
                r_outValid <= 1'b1;
                r_outData  <= w_selData;
                r_outSrc   <= w_gntIdx;
                if (bus.rr_en == MODE_RR) r_ptr <= w_ptrNext;
            end else begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_src   = r_outSrc;

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
Parametrised, registered N-input, WIDTH-bit selector with valid/ready handshakes on every input and on the output. It succeeds the fixed 32-bit 2:1 combinational mux family. NUM_IN and WIDTH are free parameters. A run-time mode bit chooses between static selection and fair round-robin arbitration. It sits between multiple producers (register-file read ports, ALU result sources) and a single registered consumer.

Parameters:
- NUM_IN, 4: number of input channels, >= 2.
- WIDTH, 32: data width per channel, >= 1.
- SELW, $clog2(NUM_IN): select/index width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rr_en  input  1  0 = static select via sel; 1 = round-robin.
- sel  input  SELW  channel index used when rr_en=0.
- in_valid  input  NUM_IN  per-channel valid.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- in_ready  output  NUM_IN  per-channel ready; one-hot or zero.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst_n=0.
  - Any in-flight word is discarded.
- load = ~out_valid | out_ready. The one-deep output register can accept a word this cycle.
- Grant, combinational. Only one grant index g may exist per cycle.
  - rr_en=0: grant exists iff sel < NUM_IN and in_valid[sel]; g = sel. If sel >= NUM_IN, no grant.
  - rr_en=1: g = first i with in_valid[i], searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1. No grant if in_valid is all zero.
- in_ready[i] = load & grant & (g == i). A transfer occurs on channel i when in_valid[i] & in_ready[i].
- Producers must not make in_valid depend on in_ready.
- On a transfer, at the next edge: out_data <= in_data slice g; out_src <= g; out_valid <= 1.
- If load=1 and there is no grant, at the next edge: out_valid <= 0. out_data and out_src hold their last values.
- If load=0 (out_valid=1, out_ready=0):
  - out_valid, out_data and out_src are held stable.
  - All in_ready bits are 0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle while out_ready=1.
- Pointer update, only on a transfer with rr_en=1: ptr <= (g == NUM_IN-1) ? 0 : g+1.
  - ptr is held otherwise, including in static mode.
- Mode change: rr_en or sel changes take effect at the next arbitration. A held output word is never altered. ptr is retained across mode changes.
- Simultaneous out_ready=1 and a new grant: the old word leaves and the new word loads in the same edge. There is no bubble.
- Fairness: with all channels continuously valid and out_ready=1, each channel is served once every NUM_IN transfers.

Decomposition:
- Shared package mux_pkg holds:
  - the mode constants MODE_STATIC=1'b0 and MODE_RR=1'b1;
  - a function computing SELW from NUM_IN, with a minimum of 1.
- Sub-module rr_pick: combinational.
  - Inputs: request vector, ptr.
  - Outputs: grant flag, grant index.
  - Implemented as a rotate / priority-find / un-rotate.
- Top module holds the mode mux, the ptr register and the output register.

Test Plan (NUM_IN=4, WIDTH=32 unless noted):
- Static grant. rr_en=0, sel=2, in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1.
  - Same cycle: in_ready=4'b0100.
  - Next cycle: out_valid=1, out_data=DEADBEEF, out_src=2.
- Round-robin sweep. rr_en=1, in_valid=4'b1111 held, out_ready=1.
  - out_src sequence is 0,1,2,3,0,1 on consecutive cycles.
  - There are no gaps in out_valid.
- Sparse round-robin with wrap. rr_en=1, in_valid=4'b1010.
  - out_src alternates 1,3,1,3.
  - After the transfer from 3, ptr=0.
- Backpressure. Start with out_valid=1, out_data=32'h11111111, then drive out_ready=0 for 3 cycles with all inputs valid.
  - out_data and out_src stay unchanged and in_ready=0 throughout.
  - Raise out_ready=1: the next grant loads on that edge.
- Out-of-range select. NUM_IN=3, rr_en=0, sel=3, in_valid=3'b111.
  - in_ready=0 and out_valid falls to 0 after the pending word drains.
- Reset mid-stream. Assert rst_n=0 between clock edges while out_valid=1.
  - out_valid=0, out_data=0, out_src=0 immediately.
  - After release with all inputs valid, the first round-robin out_src is 0.
